// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync: conditions a raw, bouncing switch into a clean level
// for downstream flip-flops. A synchronizer chain feeds a counter-based
// debounce FSM; accepted transitions also produce one-cycle rise/fall pulses.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   STABLE_LOW  | accepted level 0, waiting for a 1 candidate
//   WAIT_HIGH   | qualifying a 0->1 candidate, counting samples
//   STABLE_HIGH | accepted level 1, waiting for a 0 candidate
//   WAIT_LOW    | qualifying a 1->0 candidate, counting samples
module switch_debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic input_clock1_1,
  input  logic input_reset1_2,
  input  logic input_input_switch1_3,
  output logic output_debounced_0_4,
  output logic output_rise_pulse_0_5,
  output logic output_fall_pulse_0_6,
  output logic output_busy_0_7
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift the raw switch level through the synchronizer chain.
  always_ff @(posedge input_clock1_1 or posedge input_reset1_2) begin
    if (input_reset1_2) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], input_input_switch1_3};
    end
  end

  // Debounce FSM; level, pulses and busy are all registered with the state.
  always_ff @(posedge input_clock1_1 or posedge input_reset1_2) begin
    if (input_reset1_2) begin
      state                 <= STABLE_LOW;
      cnt                   <= '0;
      output_debounced_0_4  <= 1'b0;
      output_rise_pulse_0_5 <= 1'b0;
      output_fall_pulse_0_6 <= 1'b0;
      output_busy_0_7       <= 1'b0;
    end else begin
      output_rise_pulse_0_5 <= 1'b0;
      output_fall_pulse_0_6 <= 1'b0;
      case (state)
        STABLE_LOW: begin
          output_debounced_0_4 <= 1'b0;
          if (sync_s) begin
            state           <= WAIT_HIGH;
            cnt             <= CNT_WIDTH'(1);
            output_busy_0_7 <= 1'b1;
          end else begin
            cnt             <= '0;
            output_busy_0_7 <= 1'b0;
          end
        end
        WAIT_HIGH: begin
          if (!sync_s) begin
            // glitch: drop the candidate silently
            state           <= STABLE_LOW;
            cnt             <= '0;
            output_busy_0_7 <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state                 <= STABLE_HIGH;
            cnt                   <= '0;
            output_debounced_0_4  <= 1'b1;
            output_rise_pulse_0_5 <= 1'b1;
            output_busy_0_7       <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HIGH: begin
          output_debounced_0_4 <= 1'b1;
          if (!sync_s) begin
            state           <= WAIT_LOW;
            cnt             <= CNT_WIDTH'(1);
            output_busy_0_7 <= 1'b1;
          end else begin
            cnt             <= '0;
            output_busy_0_7 <= 1'b0;
          end
        end
        WAIT_LOW: begin
          if (sync_s) begin
            state           <= STABLE_HIGH;
            cnt             <= '0;
            output_busy_0_7 <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state                 <= STABLE_LOW;
            cnt                   <= '0;
            output_debounced_0_4  <= 1'b0;
            output_fall_pulse_0_6 <= 1'b1;
            output_busy_0_7       <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state                <= STABLE_LOW;
          cnt                  <= '0;
          output_debounced_0_4 <= 1'b0;
          output_busy_0_7      <= 1'b0;
        end
      endcase
    end
  end

endmodule
